// File: rtl/ray_slice_sequencer_pkg.sv
// ray_pkg: shared constants and types for the raycaster column sweep.
//   NUM_SLICES  - screen columns per frame
//   STEP_E      - per-slice angle step, eighths of a degree
//   HALF_FOV_E  - half field of view, eighths of a degree
//   FULL_TURN_E - 360 degrees in eighths; wrap modulus for angles
package ray_pkg;

  localparam int NUM_SLICES  = 160;
  localparam int STEP_E      = 3;
  localparam int HALF_FOV_E  = 240;
  localparam int FULL_TURN_E = 2880;

  localparam int SLICE_W = 8;   // slice index width
  localparam int ANG_W   = 12;  // angle width in eighths (9.3)

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_CALC     = 2'd1,
    S_ISSUE    = 2'd2,
    S_WAIT_COL = 2'd3
  } seq_state_e;

  // One ray request as presented to the datapath.
  typedef struct packed {
    logic [SLICE_W-1:0] slice_idx;
    logic [ANG_W-1:0]   angle_e;
  } ray_req_t;

endpackage

// File: rtl/ray_slice_sequencer_if.sv
// ray_if: ray handshake between the slice sequencer (master) and the
// ray-cast/column-draw datapath (slave).
//   ray_valid      - request valid (master -> slave)
//   ray_ready      - datapath accepts request (slave -> master)
//   col_done       - column for accepted ray has been drawn (slave -> master)
//   slice_idx      - screen column of the request
//   ray_angle_int  - ray angle, integer degrees 0..359
//   ray_angle_frac - ray angle, eighths of a degree
interface ray_if;
  logic       ray_valid;
  logic       ray_ready;
  logic       col_done;
  logic [7:0] slice_idx;
  logic [8:0] ray_angle_int;
  logic [2:0] ray_angle_frac;

  modport master (
    output ray_valid, slice_idx, ray_angle_int, ray_angle_frac,
    input  ray_ready, col_done
  );

  modport slave (
    input  ray_valid, slice_idx, ray_angle_int, ray_angle_frac,
    output ray_ready, col_done
  );
endinterface

// File: rtl/ray_slice_sequencer_angle_calc.sv
// ray_angle_calc: combinational absolute ray angle for one screen slice.
//   slice_idx - screen column 0..NUM_SLICES-1
//   heading_e - player heading in eighths of a degree (0..2879)
//   angle_e   - heading + slice*STEP - HALF_FOV, wrapped into 0..2879
// A single conditional add/subtract is enough for the wrap: the raw sum
// spans -240..3116, so it is never more than one turn out of range.
module ray_angle_calc
  import ray_pkg::*;
(
  input  logic [SLICE_W-1:0] slice_idx,
  input  logic [ANG_W-1:0]   heading_e,
  output logic [ANG_W-1:0]   angle_e
);

  localparam logic signed [12:0] HALF_S = 13'(HALF_FOV_E);
  localparam logic signed [12:0] FULL_S = 13'(FULL_TURN_E);

  logic [8:0]         offset_e;
  logic signed [12:0] sum;
  logic signed [12:0] wrapped;

  always_comb begin
    offset_e = 9'(slice_idx * STEP_E);
    sum      = $signed({1'b0, heading_e}) + $signed({4'b0, offset_e}) - HALF_S;
    if (sum < 0)
      wrapped = sum + FULL_S;
    else if (sum >= FULL_S)
      wrapped = sum - FULL_S;
    else
      wrapped = sum;
    angle_e = wrapped[ANG_W-1:0];
  end

endmodule

// File: rtl/ray_slice_sequencer.sv
// ray_slice_sequencer: per-frame column sweep controller.
// On frame_start it latches the heading, then for each slice 0..NUM_SLICES-1
// computes the ray angle, offers it to the datapath (valid/ready) and waits
// for col_done before moving on. All outputs are registered.
//   clk, resetn          - clock, async active-low reset
//   frame_start          - one-cycle pulse, starts a sweep when idle
//   heading_int/_frac    - player heading, degrees / eighths
//   ray                  - ray_if master: request out, ready/col_done in
//   busy                 - sweep in progress
//   frame_done           - one-cycle pulse after the last column completes
module ray_slice_sequencer
  import ray_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       frame_start,
  input  logic [8:0] heading_int,
  input  logic [2:0] heading_frac,
  ray_if.master      ray,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [SLICE_W-1:0] LAST_SLICE = SLICE_W'(NUM_SLICES - 1);

  seq_state_e       state_q, state_d;
  logic [ANG_W-1:0] heading_q, heading_d;
  ray_req_t         req_q, req_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [ANG_W-1:0] calc_angle;

  ray_angle_calc u_calc (
    .slice_idx (req_q.slice_idx),
    .heading_e (heading_q),
    .angle_e   (calc_angle)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      heading_q <= '0;
      req_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      heading_q <= heading_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    heading_d = heading_q;
    req_d     = req_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          // {int, frac} is exactly int*8 + frac
          heading_d       = {heading_int, heading_frac};
          req_d.slice_idx = '0;
          busy_d          = 1'b1;
          state_d         = S_CALC;
        end
      end
      S_CALC: begin
        req_d.angle_e = calc_angle;
        valid_d       = 1'b1;
        state_d       = S_ISSUE;
      end
      S_ISSUE: begin
        if (ray.ray_ready) begin
          valid_d = 1'b0;
          state_d = S_WAIT_COL;
        end
      end
      S_WAIT_COL: begin
        if (ray.col_done) begin
          if (req_q.slice_idx == LAST_SLICE) begin
            busy_d          = 1'b0;
            done_d          = 1'b1;
            req_d.slice_idx = '0;
            state_d         = S_IDLE;
          end else begin
            req_d.slice_idx = req_q.slice_idx + 1'b1;
            state_d         = S_CALC;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign ray.ray_valid      = valid_q;
  assign ray.slice_idx      = req_q.slice_idx;
  assign ray.ray_angle_int  = req_q.angle_e[ANG_W-1:3];
  assign ray.ray_angle_frac = req_q.angle_e[2:0];
  assign busy               = busy_q;
  assign frame_done         = done_q;

endmodule

// File: tb/tb_ray_slice_sequencer.sv
// Directed bench for ray_slice_sequencer: reset, full sweeps at two
// headings, back-to-back frames, stalls and ignored stray inputs.
module tb_ray_slice_sequencer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       frame_start;
  logic [8:0] heading_int;
  logic [2:0] heading_frac;
  logic       busy;
  logic       frame_done;

  ray_if rif();

  ray_slice_sequencer dut (
    .clk          (clk),
    .resetn       (resetn),
    .frame_start  (frame_start),
    .heading_int  (heading_int),
    .heading_frac (heading_frac),
    .ray          (rif.master),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int hs_cnt = 0;
  int fd_cnt = 0;
  int hs_b, fd_b;
  int first_wait;
  int bad_idx, bad_ang, bad_hs, bad_stable;
  int got_idx [160];
  int got_ang [160];

  // handshakes counted where the DUT sees them
  always @(posedge clk) if (rif.ray_valid && rif.ray_ready) hs_cnt++;
  always @(negedge clk) if (frame_done) fd_cnt++;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expected angle in eighths from the defined arithmetic
  function automatic int exp_angle(input int h_e, input int s);
    int a;
    a = h_e + s * 3 - 240;
    if (a < 0) a += 2880;
    else if (a >= 2880) a -= 2880;
    return a;
  endfunction

  task automatic start(input int hi, input int hf);
    heading_int  = 9'(hi);
    heading_frac = 3'(hf);
    frame_start  = 1'b1;
    tick();
    frame_start  = 1'b0;
  endtask

  task automatic sweep(input int h_e, input int stall_at, input int reset_at);
    int w;
    int a;
    int a_exp;
    bad_idx = 0; bad_ang = 0; bad_hs = 0; bad_stable = 0;
    for (int s = 0; s < 160; s++) begin
      w = 0;
      do begin tick(); w++; end while (!rif.ray_valid && w < 20);
      if (!rif.ray_valid) begin
        chk("ray_valid_timeout", 0, 1);
        return;
      end
      if (s == 0) first_wait = w;
      a = {rif.ray_angle_int, rif.ray_angle_frac};
      a_exp = exp_angle(h_e, s);
      got_idx[s] = int'(rif.slice_idx);
      got_ang[s] = a;
      if (got_idx[s] != s) bad_idx++;
      if (a != a_exp) bad_ang++;

      if (s == reset_at) begin
        chk("pre_reset_valid", rif.ray_valid, 1);
        chk("pre_reset_idx", rif.slice_idx, s);
        #2 resetn = 1'b0;
        #1;
        chk("rst_async_valid", rif.ray_valid, 0);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_idx", rif.slice_idx, 0);
        chk("rst_async_ang_int", rif.ray_angle_int, 0);
        chk("rst_async_ang_frac", rif.ray_angle_frac, 0);
        chk("rst_async_fdone", frame_done, 0);
        tick();
        resetn = 1'b1;
        tick();
        chk("post_rst_idle_busy", busy, 0);
        chk("post_rst_idle_valid", rif.ray_valid, 0);
        return;
      end

      if (s == stall_at) begin
        // stall with stray frame_start, col_done and a heading change
        rif.ray_ready   = 1'b0;
        frame_start     = 1'b1;
        rif.col_done    = 1'b1;
        heading_int     = 9'd100;
        for (int k = 0; k < 5; k++) begin
          tick();
          frame_start  = 1'b0;
          rif.col_done = 1'b0;
          if (!rif.ray_valid || rif.slice_idx != 8'(s) ||
              {rif.ray_angle_int, rif.ray_angle_frac} != 12'(a_exp))
            bad_stable++;
        end
        rif.ray_ready = 1'b1;
      end

      tick();
      if (rif.ray_valid) bad_hs++;
      rif.col_done = 1'b1;
      tick();
      rif.col_done = 1'b0;
    end
    chk("frame_done_pulse", frame_done, 1);
    chk("busy_end", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    resetn       = 1'b0;
    frame_start  = 1'b0;
    heading_int  = '0;
    heading_frac = '0;
    rif.ray_ready = 1'b1;
    rif.col_done  = 1'b0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", rif.ray_valid, 0);
    chk("rst_fdone", frame_done, 0);
    chk("rst_idx", rif.slice_idx, 0);
    chk("rst_ang_int", rif.ray_angle_int, 0);
    chk("rst_ang_frac", rif.ray_angle_frac, 0);
    resetn = 1'b1;
    tick();

    // sweep killed by reset at slice 37
    start(0, 0);
    sweep(0, -1, 37);

    // full sweep at heading 0.0
    hs_b = hs_cnt; fd_b = fd_cnt;
    start(0, 0);
    chk("busy_start", busy, 1);
    sweep(0, -1, -1);
    chk("h0_first_wait", first_wait, 1);
    chk("h0_s0_idx", got_idx[0], 0);
    chk("h0_s0", got_ang[0], 330 * 8 + 0);
    chk("h0_s1", got_ang[1], 330 * 8 + 3);
    chk("h0_s80", got_ang[80], 0);
    chk("h0_s159", got_ang[159], 29 * 8 + 5);
    chk("h0_idx_seq", bad_idx, 0);
    chk("h0_ang_seq", bad_ang, 0);
    chk("h0_accept", bad_hs, 0);

    // back-to-back frame at 350.5 with stall + stray inputs at slice 5
    start(350, 4);
    chk("h0_handshakes", hs_cnt - hs_b, 160);
    chk("h0_frame_done_cnt", fd_cnt - fd_b, 1);
    hs_b = hs_cnt; fd_b = fd_cnt;
    sweep(350 * 8 + 4, 5, -1);
    chk("b2b_first_wait", first_wait, 1);
    chk("h350_s0_idx", got_idx[0], 0);
    chk("h350_s0", got_ang[0], 320 * 8 + 4);
    chk("h350_s159", got_ang[159], 20 * 8 + 1);
    chk("h350_stall_stable", bad_stable, 0);
    chk("h350_ang_seq", bad_ang, 0);
    chk("h350_idx_seq", bad_idx, 0);
    chk("h350_accept", bad_hs, 0);
    tick(); tick();
    chk("h350_handshakes", hs_cnt - hs_b, 160);
    chk("h350_frame_done_cnt", fd_cnt - fd_b, 1);
    chk("idle_fdone", frame_done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_valid", rif.ray_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
